// File: rtl/calc_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing a combinational calculator.
// Optional divide-by-zero short-circuit is enabled by defining CALC_DIV0_GUARD_EN.
module calc_arbiter #(
    parameter int N       = 4,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic [3:0]     a_op,
    input  logic [N-1:0]   a_x,
    input  logic [N-1:0]   a_y,
    input  logic           b_valid,
    output logic           b_ready,
    input  logic [3:0]     b_op,
    input  logic [N-1:0]   b_x,
    input  logic [N-1:0]   b_y,
    output logic [3:0]     alu_op,
    output logic [N-1:0]   alu_x,
    output logic [N-1:0]   alu_y,
    input  logic [2*N-1:0] alu_res,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_res,
    output logic [3:0]     rsp_flags
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

    state_t         state;
    logic           last_grant;
    logic [3:0]     cnt;
    logic           win_b;
    logic           accept;
    logic [3:0]     acc_op;
    logic [N-1:0]   acc_x;
    logic [N-1:0]   acc_y;
    logic           acc_div0;
    logic [3:0]     res_flags;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        win_b = 1'b0;
        if (a_valid && b_valid)
            win_b = ~last_grant;
        else if (b_valid)
            win_b = 1'b1;
    end

    assign a_ready = (state == IDLE) && a_valid && !win_b;
    assign b_ready = (state == IDLE) && b_valid && win_b;
    assign accept  = a_ready || b_ready;

    assign acc_op = win_b ? b_op : a_op;
    assign acc_x  = win_b ? b_x  : a_x;
    assign acc_y  = win_b ? b_y  : a_y;

    always_comb begin
        acc_div0 = 1'b0;
`ifdef CALC_DIV0_GUARD_EN
        acc_div0 = ((acc_op == 4'b0011) || (acc_op == 4'b0100)) && (acc_y == '0);
`endif
    end

    // {E,C,N,Z}; E only ever comes from the divide-by-zero short-circuit.
    assign res_flags = {1'b0, |alu_res[2*N-1:N], alu_res[N-1], alu_res == '0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            alu_op     <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_res    <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_op     <= acc_op;
                        alu_x      <= acc_x;
                        alu_y      <= acc_y;
                        rsp_id     <= win_b;
                        last_grant <= win_b;
                        cnt        <= '0;
                        if (acc_div0) begin
                            rsp_res   <= '0;
                            rsp_flags <= 4'b1001;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        rsp_res   <= alu_res;
                        rsp_flags <= res_flags;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter: vector table plus arbitration, stall and reset sequences.
module tb_calc_arbiter;
    localparam int N   = 4;
    localparam int LAT = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           a_valid, b_valid;
    logic           a_ready, b_ready;
    logic [3:0]     a_op, b_op;
    logic [N-1:0]   a_x, a_y, b_x, b_y;
    logic [3:0]     alu_op;
    logic [N-1:0]   alu_x, alu_y;
    logic [2*N-1:0] alu_res;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [2*N-1:0] rsp_res;
    logic [3:0]     rsp_flags;

    calc_arbiter #(.N(N), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_x(a_x), .a_y(a_y),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_x(b_x), .b_y(b_y),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] calc(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
        logic [7:0] r;
        case (op)
            4'd0:    r = {4'b0, x} + {4'b0, y};
            4'd1:    r = {4'b0, x} - {4'b0, y};
            4'd2:    r = {4'b0, x} * {4'b0, y};
            4'd3:    r = (y == 0) ? 8'hFF : {4'b0, x / y};
            4'd4:    r = (y == 0) ? 8'hFF : {4'b0, x % y};
            default: r = {4'b0, x & y};
        endcase
        return r;
    endfunction

    always_comb alu_res = calc(alu_op, alu_x, alu_y);

    typedef struct {
        logic       id;
        logic [7:0] res;
        logic [3:0] flags;
    } exp_t;

    typedef struct {
        logic       who;
        logic [3:0] op;
        logic [3:0] x;
        logic [3:0] y;
        int         lat;
    } vec_t;

    function automatic exp_t expect_of(input logic id, input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        e.id  = id;
        e.res = calc(op, x, y);
        e.flags = {1'b0, |e.res[7:4], e.res[3], e.res == 8'h00};
`ifdef CALC_DIV0_GUARD_EN
        if ((op == 4'd3 || op == 4'd4) && y == 0) begin
            e.res   = 8'h00;
            e.flags = 4'b1001;
        end
`endif
        return e;
    endfunction

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb_q[$];
    int   grant_q[$];
    int   grant_t[$];
    exp_t e_mon;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_valid && a_ready) begin
                sb_q.push_back(expect_of(1'b0, a_op, a_x, a_y));
                grant_q.push_back(0);
                grant_t.push_back(cyc);
            end
            if (b_valid && b_ready) begin
                sb_q.push_back(expect_of(1'b1, b_op, b_x, b_y));
                grant_q.push_back(1);
                grant_t.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e_mon = sb_q.pop_front();
                    check("rsp_id", {31'b0, rsp_id}, {31'b0, e_mon.id});
                    check("rsp_res", {24'b0, rsp_res}, {24'b0, e_mon.res});
                    check("rsp_flags", {28'b0, rsp_flags}, {28'b0, e_mon.flags});
                end
            end
        end
    end

    task automatic drive(input logic who, input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
        if (who) begin
            b_op = op; b_x = x; b_y = y; b_valid = 1'b1;
        end else begin
            a_op = op; a_x = x; a_y = y; a_valid = 1'b1;
        end
    endtask

    task automatic wait_hs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((a_valid && a_ready) || (b_valid && b_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
    endtask

    vec_t vt[6];
    bit   ok;
    int   n;

    initial begin
        rst = 1'b1;
        a_valid = 0; b_valid = 0; rsp_ready = 1'b1;
        a_op = 0; a_x = 0; a_y = 0; b_op = 0; b_x = 0; b_y = 0;

        vt[0] = '{1'b0, 4'd0, 4'd7,  4'd9,  2};
        vt[1] = '{1'b0, 4'd1, 4'd5,  4'd5,  2};
        vt[2] = '{1'b1, 4'd2, 4'd3,  4'd5,  2};
        vt[3] = '{1'b0, 4'd0, 4'd15, 4'd15, 2};
`ifdef CALC_DIV0_GUARD_EN
        vt[4] = '{1'b1, 4'd3, 4'd9,  4'd0,  1};
`else
        vt[4] = '{1'b1, 4'd3, 4'd9,  4'd0,  2};
`endif
        vt[5] = '{1'b1, 4'd3, 4'd9,  4'd3,  2};

        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_ready", {30'b0, a_ready, b_ready}, 32'd0);
        check("rst_alu", {20'b0, alu_op, alu_x, alu_y}, 32'd0);
        check("rst_rsp", {19'b0, rsp_id, rsp_res, rsp_flags}, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(vt[i].who, vt[i].op, vt[i].x, vt[i].y);
            wait_hs(ok);
            @(posedge clk); #1;
            a_valid = 0; b_valid = 0;
            check("busy_alu_op", {28'b0, alu_op}, {28'b0, vt[i].op});
            check("busy_alu_xy", {24'b0, alu_x, alu_y}, {24'b0, vt[i].x, vt[i].y});
            check("busy_ready", {30'b0, a_ready, b_ready}, 32'd0);
            n = 1;
            while (!rsp_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("latency", n, vt[i].lat);
            @(negedge clk);
        end

        // Continuous tie after a B grant: A,B,A,B at the minimum issue interval.
        @(posedge clk); #1;
        grant_q.delete(); grant_t.delete();
        drive(1'b0, 4'd0, 4'd1, 4'd2);
        drive(1'b1, 4'd2, 4'd3, 4'd3);
        n = 0;
        while (grant_q.size() < 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        a_valid = 0; b_valid = 0;
        check("rr_count", grant_q.size(), 32'd4);
        if (grant_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("rr_grant", grant_q[i], i % 2);
            check("rr_interval", grant_t[1] - grant_t[0], LAT + 2);
        end
        drain();

        // Response stall: outputs held, no accept while B waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd7, 4'd9);
        wait_hs(ok);
        @(posedge clk); #1;
        a_valid = 0;
        drive(1'b1, 4'd1, 4'd3, 4'd1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, rsp_valid}, 32'd1);
            check("stall_rsp", {19'b0, rsp_id, rsp_res, rsp_flags}, {19'b0, 1'b0, 8'h10, 4'b0100});
            check("stall_ready", {30'b0, a_ready, b_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_hs_no_accept", {30'b0, rsp_valid, b_ready}, 32'd2);
        wait_hs(ok);
        @(posedge clk); #1;
        b_valid = 0;
        drain();

        // Reset mid-EXEC drops the op and restores A priority on the next tie.
        @(posedge clk); #1;
        drive(1'b0, 4'd2, 4'd3, 4'd3);
        wait_hs(ok);
        @(posedge clk); #1;
        a_valid = 0;
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_alu", {20'b0, alu_op, alu_x, alu_y}, 32'd0);
        sb_q.delete();
        #1 rst = 1'b0;
        @(posedge clk); #1;
        grant_q.delete(); grant_t.delete();
        drive(1'b0, 4'd0, 4'd2, 4'd2);
        drive(1'b1, 4'd0, 4'd4, 4'd4);
        wait_hs(ok);
        if (ok) check("tie_after_reset", grant_q[grant_q.size() - 1], 32'd0);
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        drain();

        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
